bp_btb: RTL and testbench
=========================

Name: bp_btb

Overview:
- Fetch-side branch predictor: direct-mapped branch target buffer with a 2-bit saturating counter per entry.
- Drives the predicted-taken flag and predicted target PC that travel down the pipeline to the execute-stage branch resolver.
- Trains from that resolver's outcome (true direction, resolved target, mispredict flag) the cycle a branch is in EX.
- PCs are word addresses; the sequential successor is PC+1.

Parameters:
- PC_BITS, 12, width of every PC in the core; all PC arithmetic is modulo 2^PC_BITS.
- IDX_BITS, 4, index width; table holds 2^IDX_BITS entries; must satisfy 1 <= IDX_BITS < PC_BITS.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- F_pc  input  PC_BITS  PC of the instruction being fetched this cycle
- F_BP_taken  output  1  predicted taken for F_pc
- F_BP_target_pc  output  PC_BITS  predicted next PC for F_pc
- EX_brn  input  1  a branch/jump is resolving in EX this cycle; update qualifier
- EX_pc  input  PC_BITS  PC of the resolving branch
- EX_true_taken  input  1  actual direction of the resolving branch
- EX_target_pc  input  PC_BITS  resolved next PC (branch target when taken)
- EX_taken  input  1  resolver flagged a mispredict/flush; used only by the statistics feature

Behaviour:
- Entry fields: valid, tag = PC[PC_BITS-1:IDX_BITS], target[PC_BITS-1:0], ctr[1:0].
- Index = PC[IDX_BITS-1:0].
- Reset (rst=1 at a clock edge): every entry gets valid=0, ctr=2'b01, target=0, tag=0.
- Outputs are combinational and need no reset value. After reset every lookup misses, so F_BP_taken=0 and F_BP_target_pc=F_pc+1.
- Lookup is combinational, zero latency. hit = valid[idx] && tag[idx]==F_pc tag bits.
  - F_BP_taken = hit && ctr[1].
  - F_BP_target_pc = target[idx] when F_BP_taken; otherwise F_pc+1, truncated to PC_BITS (wraps from all-ones to 0).
- Update happens at a clock edge only when EX_brn=1 and rst=0. ex_hit is the lookup of EX_pc.
  - ex_hit, EX_true_taken=1: ctr = min(ctr+1, 3); target = EX_target_pc.
  - ex_hit, EX_true_taken=0: ctr = max(ctr-1, 0); target unchanged.
  - miss, EX_true_taken=1: allocate. Set valid=1, tag from EX_pc, target=EX_target_pc, ctr=2'b10 (weakly taken); this overwrites any existing entry at that index.
  - miss, EX_true_taken=0: no state change (not-taken branches are never allocated).
- Simultaneous lookup and update to the same index: the lookup returns the pre-update contents (no write-through bypass). The new state is visible from the next cycle.
- rst=1 together with EX_brn=1: reset wins and no update is applied.
- Only one update per cycle. The table holds no pending state, so reset mid-operation loses nothing beyond training history.

Optional Feature:
- Macro: BP_STATS_EN.
- When defined, two outputs are added:
  - stat_branches [31:0]: increments on each cycle with EX_brn=1.
  - stat_mispredicts [31:0]: increments on each cycle with EX_brn=1 and EX_taken=1.
  - Both reset to 0 on rst, wrap at 2^32, and update on the same edge as the table.
- When undefined: the ports and counters do not exist and EX_taken is unused. Predictor behaviour is identical either way.

Test Plan:
- Reset, then F_pc=12'h010 -> F_BP_taken=0, F_BP_target_pc=12'h011; F_pc=12'hFFF -> target 12'h000 (wrap).
- One update EX_brn=1, EX_pc=12'h020, EX_true_taken=1, EX_target_pc=12'h080; next cycle F_pc=12'h020 -> taken=1, target=12'h080 (ctr=2).
- Two not-taken updates for 12'h020 -> after the first, ctr=1 and F_pc=12'h020 predicts taken=0, target=12'h021; after the second, ctr=0. Three taken updates after that -> ctr saturates at 3 and a fourth taken update leaves it at 3.
- Alias: train 12'h020 taken, then allocate 12'h030 (same index, different tag) taken with target 12'h0C0 -> F_pc=12'h020 now misses (target 12'h021); 12'h030 hits with 12'h0C0.
- Same-cycle read/write: F_pc=EX_pc=12'h040, first taken update -> that cycle taken=0, target=12'h041; next cycle taken=1. Assert rst in the same cycle as an update -> entry stays invalid.
- BP_STATS_EN: apply 5 EX_brn pulses, 2 of them with EX_taken=1 -> stat_branches=5, stat_mispredicts=2; assert rst -> both 0.

Source files
------------

// File: rtl/bp_btb_if.sv
// Fetch/execute port bundle for the bp_btb branch target buffer.
// Statistics outputs exist only when BP_STATS_EN is defined.
interface bp_btb_if #(
  parameter int PC_BITS = 12
);
  logic [PC_BITS-1:0] F_pc;
  logic               F_BP_taken;
  logic [PC_BITS-1:0] F_BP_target_pc;
  logic               EX_brn;
  logic [PC_BITS-1:0] EX_pc;
  logic               EX_true_taken;
  logic [PC_BITS-1:0] EX_target_pc;
  logic               EX_taken;
`ifdef BP_STATS_EN
  logic [31:0]        stat_branches;
  logic [31:0]        stat_mispredicts;

  modport master (
    output F_pc, EX_brn, EX_pc, EX_true_taken, EX_target_pc, EX_taken,
    input  F_BP_taken, F_BP_target_pc, stat_branches, stat_mispredicts
  );
  modport slave (
    input  F_pc, EX_brn, EX_pc, EX_true_taken, EX_target_pc, EX_taken,
    output F_BP_taken, F_BP_target_pc, stat_branches, stat_mispredicts
  );
`else
  modport master (
    output F_pc, EX_brn, EX_pc, EX_true_taken, EX_target_pc, EX_taken,
    input  F_BP_taken, F_BP_target_pc
  );
  modport slave (
    input  F_pc, EX_brn, EX_pc, EX_true_taken, EX_target_pc, EX_taken,
    output F_BP_taken, F_BP_target_pc
  );
`endif
endinterface

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Optional branch/mispredict counters are enabled with BP_STATS_EN.
module bp_btb #(
  parameter int PC_BITS  = 12,
  parameter int IDX_BITS = 4
) (
  input  logic     clk,
  input  logic     rst,
  bp_btb_if.slave  bus
);
  localparam int unsigned ENTRIES  = 1 << IDX_BITS;
  localparam int          TAG_BITS = PC_BITS - IDX_BITS;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [PC_BITS-1:0]  target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [IDX_BITS-1:0] f_idx, ex_idx;
  logic [TAG_BITS-1:0] f_tag, ex_tag;
  logic                f_hit, f_taken, ex_hit;

  assign f_idx  = bus.F_pc[IDX_BITS-1:0];
  assign f_tag  = bus.F_pc[PC_BITS-1:IDX_BITS];
  assign ex_idx = bus.EX_pc[IDX_BITS-1:0];
  assign ex_tag = bus.EX_pc[PC_BITS-1:IDX_BITS];

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  always_comb begin
    f_hit              = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    f_taken            = f_hit && ctr_q[f_idx][1];
    ex_hit             = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    bus.F_BP_taken     = f_taken;
    bus.F_BP_target_pc = f_taken ? target_q[f_idx] : bus.F_pc + PC_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[IDX_BITS'(i)]    <= '0;
        target_q[IDX_BITS'(i)] <= '0;
        ctr_q[IDX_BITS'(i)]    <= 2'b01;
      end
    end else if (bus.EX_brn) begin
      if (ex_hit) begin
        if (bus.EX_true_taken) begin
          ctr_q[ex_idx]    <= (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
          target_q[ex_idx] <= bus.EX_target_pc;
        end else begin
          ctr_q[ex_idx]    <= (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
        end
      end else if (bus.EX_true_taken) begin
        // Taken miss replaces whatever lives at this index, aliasing or not.
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= bus.EX_target_pc;
        ctr_q[ex_idx]    <= 2'b10;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.stat_branches    <= '0;
      bus.stat_mispredicts <= '0;
    end else if (bus.EX_brn) begin
      bus.stat_branches <= bus.stat_branches + 32'd1;
      if (bus.EX_taken) begin
        bus.stat_mispredicts <= bus.stat_mispredicts + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_bp_btb.sv
// Self-checking bench for bp_btb: directed plan steps followed by random traffic
// compared against a behavioural table model.
module tb_bp_btb;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bp_btb_if #(.PC_BITS(12)) bus ();
  bp_btb #(.PC_BITS(12), .IDX_BITS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Behavioural model: per-index record, counter kept as a plain integer 0..3.
  bit m_valid [16];
  int m_tag   [16];
  int m_tgt   [16];
  int m_ctr   [16];
  int m_branches    = 0;
  int m_mispredicts = 0;
  bit model_known   = 0;

  function automatic bit model_taken(input int pc);
    int idx = pc % 16;
    return m_valid[idx] && (m_tag[idx] == pc / 16) && (m_ctr[idx] >= 2);
  endfunction

  function automatic int model_target(input int pc);
    if (model_taken(pc)) return m_tgt[pc % 16];
    return (pc + 1) % 4096;
  endfunction

  task automatic model_update(input bit r, input bit brn, input int epc,
                              input bit tt, input int etgt, input bit etk);
    int idx = epc % 16;
    if (r) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
      m_branches = 0; m_mispredicts = 0; model_known = 1;
    end else if (brn) begin
      m_branches++;
      if (etk) m_mispredicts++;
      if (m_valid[idx] && m_tag[idx] == epc / 16) begin
        if (tt) begin
          m_ctr[idx] = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
          m_tgt[idx] = etgt;
        end else begin
          m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
        end
      end else if (tt) begin
        m_valid[idx] = 1; m_tag[idx] = epc / 16; m_tgt[idx] = etgt; m_ctr[idx] = 2;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, check outputs against the model (and optional
  // literal expectation), then clock and advance the model.
  task automatic cycle(input string tag, input logic r, input logic [11:0] fpc,
                       input logic brn, input logic [11:0] epc, input logic tt,
                       input logic [11:0] etgt, input logic etk,
                       input bit lit, input logic lit_t, input logic [11:0] lit_tgt);
    rst               = r;
    bus.F_pc          = fpc;
    bus.EX_brn        = brn;
    bus.EX_pc         = epc;
    bus.EX_true_taken = tt;
    bus.EX_target_pc  = etgt;
    bus.EX_taken      = etk;
    #2;
    if (model_known) begin
      chk({tag, "_taken"},  32'(bus.F_BP_taken),     32'(model_taken(int'(fpc))));
      chk({tag, "_target"}, 32'(bus.F_BP_target_pc), 32'(model_target(int'(fpc))));
`ifdef BP_STATS_EN
      chk({tag, "_stat_br"}, bus.stat_branches,    32'(m_branches));
      chk({tag, "_stat_mp"}, bus.stat_mispredicts, 32'(m_mispredicts));
`endif
    end
    if (lit) begin
      chk({tag, "_lit_taken"},  32'(bus.F_BP_taken),     32'(lit_t));
      chk({tag, "_lit_target"}, 32'(bus.F_BP_target_pc), 32'(lit_tgt));
    end
    @(posedge clk);
    model_update(r, brn, int'(epc), tt, int'(etgt), etk);
    #1;
  endtask

  task automatic upd(input string tag, input logic [11:0] epc, input logic tt,
                     input logic [11:0] etgt);
    cycle(tag, 1'b0, 12'h000, 1'b1, epc, tt, etgt, 1'b0, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic peek(input string tag, input logic [11:0] fpc,
                      input logic et, input logic [11:0] etgt);
    cycle(tag, 1'b0, fpc, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b1, et, etgt);
  endtask

  initial begin
    logic [11:0] rf, re, rt;
    rst = 1'b1;
    bus.F_pc = '0; bus.EX_brn = 1'b0; bus.EX_pc = '0;
    bus.EX_true_taken = 1'b0; bus.EX_target_pc = '0; bus.EX_taken = 1'b0;
    #1;
    cycle("rst0", 1'b1, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000);
    cycle("rst1", 1'b1, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000);

    peek("miss_010", 12'h010, 1'b0, 12'h011);
    peek("wrap_fff", 12'hFFF, 1'b0, 12'h000);

    upd ("alloc_020", 12'h020, 1'b1, 12'h080);
    peek("hit_020",   12'h020, 1'b1, 12'h080);
    upd ("nt1_020",   12'h020, 1'b0, 12'h000);
    peek("ctr1_020",  12'h020, 1'b0, 12'h021);
    upd ("nt2_020",   12'h020, 1'b0, 12'h000);
    peek("ctr0_020",  12'h020, 1'b0, 12'h021);
    upd ("t1_020",    12'h020, 1'b1, 12'h080);
    peek("up1_020",   12'h020, 1'b0, 12'h021);
    upd ("t2_020",    12'h020, 1'b1, 12'h080);
    peek("up2_020",   12'h020, 1'b1, 12'h080);
    upd ("t3_020",    12'h020, 1'b1, 12'h080);
    upd ("t4_020",    12'h020, 1'b1, 12'h080);
    upd ("sat_nt_020", 12'h020, 1'b0, 12'h000);
    peek("sat3_020",  12'h020, 1'b1, 12'h080);
    upd ("sat_nt2_020", 12'h020, 1'b0, 12'h000);
    peek("sat1_020",  12'h020, 1'b0, 12'h021);

    upd ("retrain_020", 12'h020, 1'b1, 12'h080);
    upd ("alias_030",   12'h030, 1'b1, 12'h0C0);
    peek("alias_miss_020", 12'h020, 1'b0, 12'h021);
    peek("alias_hit_030",  12'h030, 1'b1, 12'h0C0);

    cycle("same_040", 1'b0, 12'h040, 1'b1, 12'h040, 1'b1, 12'h100, 1'b0, 1'b1, 1'b0, 12'h041);
    peek("after_040", 12'h040, 1'b1, 12'h100);
    cycle("rst_upd_050", 1'b1, 12'h000, 1'b1, 12'h050, 1'b1, 12'h200, 1'b0, 1'b0, 1'b0, 12'h000);
    peek("rstwin_050", 12'h050, 1'b0, 12'h051);
    peek("rstclr_040", 12'h040, 1'b0, 12'h041);

    for (int i = 0; i < 5; i++) begin
      cycle("stat_pulse", 1'b0, 12'h300, 1'b1, 12'h123, 1'b0, 12'h000,
            (i == 1 || i == 3), 1'b0, 1'b0, 12'h000);
    end
`ifdef BP_STATS_EN
    chk("stat_br_5", bus.stat_branches,    32'd5);
    chk("stat_mp_2", bus.stat_mispredicts, 32'd2);
    cycle("stat_rst", 1'b1, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000);
    chk("stat_br_0", bus.stat_branches,    32'd0);
    chk("stat_mp_0", bus.stat_mispredicts, 32'd0);
`endif

    for (int i = 0; i < 600; i++) begin
      rf = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 63));
      re = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 63));
      rt = 12'($urandom);
      cycle("rand", ($urandom_range(0, 59) == 0), rf, 1'($urandom), re,
            1'($urandom), rt, 1'($urandom), 1'b0, 1'b0, 12'h000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
